// File: rtl/ps2_key_packer_pkg.sv
// Shared constants and types for the PS/2 key packer: scan-code prefixes, FSM states
// and the multi-part sequences that are merged into a single event.
package ps2_key_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    typedef enum logic [1:0] {
        IDLE,
        PREFIX,
        PAUSE
    } ps2_state_t;

    localparam logic [63:0] SEQ_FSHIFT_MK     = 64'h0000_0000_0000_E012;
    localparam logic [63:0] SEQ_PRT_MK_TAIL   = 64'h0000_0000_0000_E07C;
    localparam logic [63:0] SEQ_PRT_MK        = 64'h0000_0000_E012_E07C;
    localparam logic [63:0] SEQ_PRT_BRK_HEAD  = 64'h0000_0000_00E0_F07C;
    localparam logic [63:0] SEQ_PRT_BRK_TAIL  = 64'h0000_0000_00E0_F012;
    localparam logic [63:0] SEQ_PRT_BRK       = 64'h0000_E0F0_7CE0_F012;

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PS2_EXT) || (b == PS2_BRK);
    endfunction

endpackage

// File: rtl/ps2_key_packer_if.sv
// Byte-in / event-out bundle between the keyboard byte source and the packer.
interface ps2_key_packer_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic [64:0] ps2_key;
    logic        seq_dropped;

    modport master (output in_data, output in_valid, input ps2_key, input seq_dropped);
    modport slave  (input in_data, input in_valid, output ps2_key, output seq_dropped);
endinterface

// File: rtl/ps2_seq_timer.sv
// Saturating idle counter; clear wins over enable, holds at MAX_COUNT.
module ps2_seq_timer #(
    parameter int MAX_COUNT = 24000,
    parameter int WIDTH     = $clog2(MAX_COUNT + 1)
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != WIDTH'(MAX_COUNT))) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/ps2_key_packer.sv
// Groups raw PS/2 scan-code bytes into complete key sequences and publishes each one
// as a toggle-flagged 65-bit event word; PrtScr halves are merged via a pending slot.
module ps2_key_packer
    import ps2_key_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 24000
) (
    input logic             clk_sys,
    input logic             reset,
    ps2_key_packer_if.slave bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    ps2_state_t    state_reg, state_next;
    logic [63:0]   acc_reg, acc_shift;
    logic [3:0]    cnt_reg, cnt_inc;
    logic          pend_valid_reg;
    logic [63:0]   pend_seq_reg;
    logic          defer_valid_reg;
    logic [63:0]   defer_seq_reg;
    logic [64:0]   key_reg;
    logic          dropped_reg;
    logic          seq_done, seq_drop;
    logic [TW-1:0] timer_count;
    logic          timeout_hit, timer_clr, timer_en;

    assign bus.ps2_key     = key_reg;
    assign bus.seq_dropped = dropped_reg;

    assign acc_shift   = {acc_reg[55:0], bus.in_data};
    assign cnt_inc     = cnt_reg + 4'd1;
    assign timeout_hit = (timer_count == TW'(TIMEOUT_CYCLES)) && !bus.in_valid;
    assign timer_en    = (state_reg != IDLE) || pend_valid_reg;
    // Clearing on the hit itself stops a saturated count from firing again.
    assign timer_clr   = bus.in_valid || timeout_hit;

    ps2_seq_timer #(.MAX_COUNT(TIMEOUT_CYCLES), .WIDTH(TW)) u_timer (
        .clk_sys (clk_sys),
        .reset   (reset),
        .clr     (timer_clr),
        .en      (timer_en),
        .count   (timer_count)
    );

    always_comb begin
        state_next = state_reg;
        seq_done   = 1'b0;
        seq_drop   = 1'b0;
        if (bus.in_valid) begin
            unique case (state_reg)
                IDLE: begin
                    if (is_prefix(bus.in_data))         state_next = PREFIX;
                    else if (bus.in_data == PS2_PAUSE)  state_next = PAUSE;
                    else                                seq_done   = 1'b1;
                end
                PREFIX: begin
                    if (!is_prefix(bus.in_data)) begin
                        seq_done   = 1'b1;
                        state_next = IDLE;
                    end else if (cnt_inc > 4'd7) begin
                        seq_drop   = 1'b1;
                        state_next = IDLE;
                    end
                end
                PAUSE: begin
                    if (cnt_inc == 4'd8) begin
                        seq_done   = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            acc_reg         <= '0;
            cnt_reg         <= '0;
            pend_valid_reg  <= 1'b0;
            pend_seq_reg    <= '0;
            defer_valid_reg <= 1'b0;
            defer_seq_reg   <= '0;
            key_reg         <= '0;
            dropped_reg     <= 1'b0;
        end else begin
            dropped_reg <= 1'b0;
            if (defer_valid_reg) begin
                key_reg         <= {~key_reg[64], defer_seq_reg};
                defer_valid_reg <= 1'b0;
            end
            if (bus.in_valid) begin
                state_reg <= state_next;
                if (seq_done || seq_drop) begin
                    acc_reg <= '0;
                    cnt_reg <= '0;
                end else begin
                    acc_reg <= acc_shift;
                    cnt_reg <= cnt_inc;
                end
                if (seq_drop) dropped_reg <= 1'b1;
                if (seq_done) begin
                    if (!pend_valid_reg &&
                        (acc_shift == SEQ_FSHIFT_MK || acc_shift == SEQ_PRT_BRK_HEAD)) begin
                        pend_valid_reg <= 1'b1;
                        pend_seq_reg   <= acc_shift;
                    end else if (pend_valid_reg && pend_seq_reg == SEQ_FSHIFT_MK &&
                                 acc_shift == SEQ_PRT_MK_TAIL) begin
                        key_reg        <= {~key_reg[64], SEQ_PRT_MK};
                        pend_valid_reg <= 1'b0;
                    end else if (pend_valid_reg && pend_seq_reg == SEQ_PRT_BRK_HEAD &&
                                 acc_shift == SEQ_PRT_BRK_TAIL) begin
                        key_reg        <= {~key_reg[64], SEQ_PRT_BRK};
                        pend_valid_reg <= 1'b0;
                    end else if (pend_valid_reg) begin
                        // Held sequence goes out now; the new one follows on the next edge.
                        key_reg         <= {~key_reg[64], pend_seq_reg};
                        pend_valid_reg  <= 1'b0;
                        defer_valid_reg <= 1'b1;
                        defer_seq_reg   <= acc_shift;
                    end else begin
                        key_reg <= {~key_reg[64], acc_shift};
                    end
                end
            end else if (timeout_hit) begin
                if (state_reg != IDLE) begin
                    state_reg   <= IDLE;
                    acc_reg     <= '0;
                    cnt_reg     <= '0;
                    dropped_reg <= 1'b1;
                end
                if (pend_valid_reg) begin
                    key_reg        <= {~key_reg[64], pend_seq_reg};
                    pend_valid_reg <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_packer.sv
// Scoreboard bench: stimulus pushes expected events, a monitor pops them on each toggle/drop.
module tb_ps2_key_packer;

    localparam int TMO = 40;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_sys = ~clk_sys;

    ps2_key_packer_if bus ();

    ps2_key_packer #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    typedef struct {
        bit          is_drop;
        logic [63:0] seq;
    } exp_t;

    exp_t sb[$];
    int   ev_cycles[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic expect_key(input logic [63:0] s);
        exp_t e;
        e.is_drop = 1'b0;
        e.seq     = s;
        sb.push_back(e);
    endtask

    task automatic expect_drop();
        exp_t e;
        e.is_drop = 1'b1;
        e.seq     = '0;
        sb.push_back(e);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk_sys);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        @(negedge clk_sys);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk_sys);
        $display("byte %h sent at cycle %0d", b, cyc);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk_sys);
            n++;
        end
        chk("drain_queue_empty", 65'(sb.size()), 65'd0);
    endtask

    // Monitor: one check pair per event toggle or drop pulse.
    initial begin : monitor
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(posedge clk_sys);
            #1;
            cyc++;
            if (reset) begin
                prev = bus.ps2_key[64];
            end else begin
                if (bus.ps2_key[64] != prev) begin
                    prev = bus.ps2_key[64];
                    ev_cycles.push_back(cyc);
                    $display("event %h at cycle %0d", bus.ps2_key[63:0], cyc);
                    if (sb.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_event: got %h required none", bus.ps2_key[63:0]);
                    end else begin
                        e = sb.pop_front();
                        chk("event_kind", 65'(1'b0), 65'(e.is_drop));
                        chk("event_seq", 65'(bus.ps2_key[63:0]), 65'(e.seq));
                    end
                end
                if (bus.seq_dropped) begin
                    $display("seq_dropped at cycle %0d", cyc);
                    if (sb.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_drop: got 1 required 0");
                    end else begin
                        e = sb.pop_front();
                        chk("drop_kind", 65'(1'b1), 65'(e.is_drop));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n0;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("reset_key", bus.ps2_key, 65'd0);
        chk("reset_dropped", 65'(bus.seq_dropped), 65'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk_sys);

        // 1) single byte, updated at the strobe-sampling edge
        expect_key(64'h1C);
        @(negedge clk_sys);
        bus.in_data  = 8'h1C;
        bus.in_valid = 1'b1;
        @(posedge clk_sys);
        #1;
        chk("t1_latency", bus.ps2_key, 65'h1_0000_0000_0000_001C);
        @(negedge clk_sys);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk_sys);
        drain();

        // 2) extended break
        send(8'hE0);
        send(8'hF0);
        expect_key(64'hE0F075);
        send(8'h75);
        drain();
        chk("t2_toggle", 65'(bus.ps2_key[64]), 65'd0);

        // 3) PrtScr make and break merge
        send(8'hE0); send(8'h12); send(8'hE0);
        expect_key(64'hE012E07C);
        send(8'h7C);
        drain();
        send(8'hE0); send(8'hF0); send(8'h7C); send(8'hE0); send(8'hF0);
        expect_key(64'hE0F07CE0F012);
        send(8'h12);
        drain();

        // 4) Pause
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0);
        expect_key(64'hE11477E1F014F077);
        send(8'h77);
        drain();

        // 5) fake-shift followed by unrelated key: two events one cycle apart
        send(8'hE0); send(8'h12);
        n0 = ev_cycles.size();
        expect_key(64'hE012);
        expect_key(64'h1C);
        send(8'h1C);
        drain();
        chk("t5_two_events", 65'(ev_cycles.size() - n0), 65'd2);
        if (ev_cycles.size() - n0 == 2)
            chk("t5_gap", 65'(ev_cycles[n0+1] - ev_cycles[n0]), 65'd1);
        send(8'hE0);
        expect_key(64'hE012);
        send(8'h12);
        repeat (TMO + 10) @(negedge clk_sys);
        drain();

        // 6) dangling prefix times out, then normal key
        expect_drop();
        send(8'hE0);
        repeat (TMO + 10) @(negedge clk_sys);
        drain();
        expect_key(64'h29);
        send(8'h29);
        drain();

        // prefix overflow: eighth prefix byte discards the sequence
        for (int i = 0; i < 7; i++) send(8'hE0);
        expect_drop();
        send(8'hF0);
        drain();

        // reset in the middle of a Pause run
        send(8'hE1); send(8'h14); send(8'h77);
        @(negedge clk_sys);
        reset = 1'b1;
        #1;
        chk("t6_reset_key", bus.ps2_key, 65'd0);
        chk("t6_reset_dropped", 65'(bus.seq_dropped), 65'd0);
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
        expect_key(64'h1C);
        send(8'h1C);
        drain();
        chk("t6_after_reset", bus.ps2_key, 65'h1_0000_0000_0000_001C);

        repeat (5) @(negedge clk_sys);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
